// File: rtl/booth_mul_32bit_pkg.sv
// Shared types and step-count helper for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding (two product bits retired per step).
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  typedef enum logic [2:0] {NOP, ADD1, SUB1, ADD2, SUB2} booth_op_t;

`ifdef BOOTH_RADIX4_EN
  localparam int RADIX_SHIFT = 2;
`else
  localparam int RADIX_SHIFT = 1;
`endif

  // Recoder window: the retired multiplier bits plus the previously shifted-out bit.
  localparam int BOOTH_BITS = RADIX_SHIFT + 1;

  function automatic int steps(input int width);
    return width / RADIX_SHIFT;
  endfunction

endpackage

// File: rtl/booth_mul_32bit_if.sv
// Start/busy/done handshake and operand/product bus of the Booth multiplier.
interface booth_mul_32bit_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [WIDTH-1:0]     M;
  logic [WIDTH-1:0]     Q;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;

  modport master (output start, M, Q, input busy, done, z);
  modport slave  (input start, M, Q, output busy, done, z);
endinterface

// File: rtl/booth_mul_32bit_recoder.sv
// Combinational Booth digit recoder; window width follows BOOTH_RADIX4_EN.
module booth_recoder
  import mul_pkg::*;
(
  input  logic [BOOTH_BITS-1:0] bits,
  output booth_op_t             op
);

  always_comb begin
    op = NOP;
`ifdef BOOTH_RADIX4_EN
    case (bits)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = NOP;
    endcase
`else
    case (bits)
      2'b01:   op = ADD1;
      2'b10:   op = SUB1;
      default: op = NOP;
    endcase
`endif
  end

endmodule

// File: rtl/booth_mul_32bit.sv
// Sequential signed Booth multiplier, z = M * Q, with start/busy/done handshake.
// BOOTH_RADIX4_EN switches to radix-4 (half the steps); products are identical.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepted start
// RUN   | one Booth step per cycle, cnt counts remaining steps down
// DONE  | z just updated, done pulses, start ignored this cycle
module booth_mul_32bit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input logic              clk,
  input logic              clr,
  booth_mul_32bit_if.slave bus
);

  localparam int SH    = RADIX_SHIFT;
  localparam int AW    = WIDTH + SH;
  localparam int STEPS = steps(WIDTH);
  localparam int CW    = $clog2(STEPS + 1);

  mul_state_t          state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2*WIDTH-1:0]  z_q, z_d;
  logic [AW-1:0]       a_q, a_d;
  logic [WIDTH-1:0]    qr_q, qr_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic                q1_q, q1_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  booth_op_t           op;
  logic [AW-1:0]       m_ext;
  logic [AW-1:0]       sum;
  logic [AW-1:0]       a_step;
  logic [WIDTH-1:0]    qr_step;
  logic                q1_step;

  booth_recoder u_recoder (
    .bits ({qr_q[SH-1:0], q1_q}),
    .op   (op)
  );

  // A carries SH guard bits so +/-2M of the most negative operand cannot overflow.
  always_comb begin
    m_ext = {{SH{m_q[WIDTH-1]}}, m_q};
    case (op)
      ADD1:    sum = a_q + m_ext;
      SUB1:    sum = a_q - m_ext;
      ADD2:    sum = a_q + (m_ext << 1);
      SUB2:    sum = a_q - (m_ext << 1);
      default: sum = a_q;
    endcase
    a_step  = {{SH{sum[AW-1]}}, sum[AW-1:SH]};
    qr_step = {sum[SH-1:0], qr_q[WIDTH-1:SH]};
    q1_step = qr_q[SH-1];
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    a_d     = a_q;
    qr_d    = qr_q;
    m_d     = m_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          m_d     = bus.M;
          qr_d    = bus.Q;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(STEPS);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_step;
        qr_d  = qr_step;
        q1_d  = q1_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          z_d     = {a_step[WIDTH-1:0], qr_step};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      a_q     <= '0;
      qr_q    <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.z    = z_q;

endmodule
